// File: rtl/simd_isa_pkg.sv
// Shared SIMD ALU instruction-set definitions: opcodes, field layout and the canonical NOP.
// Imported by the encoder and by the downstream instruction decoder.
package simd_isa_pkg;

    typedef enum logic [3:0] {
        NOP      = 4'd0,
        PADD     = 4'd1,
        PSUB     = 4'd2,
        PMUL     = 4'd3,
        PAND     = 4'd4,
        POR      = 4'd5,
        PXOR     = 4'd6,
        PSHL     = 4'd7,
        PUNPKGLO = 4'd8,
        PUNPKGHI = 4'd9
    } opcode_e;

    localparam int unsigned INST_W       = 16;
    localparam int unsigned OPCODE_W     = 4;
    localparam int unsigned OPCODE_LSB   = 12;
    localparam int unsigned DMODE_W      = 3;
    localparam int unsigned DMODE_LSB    = 9;
    localparam int unsigned IMM_FLAG_BIT = 8;
    localparam int unsigned IMM_W        = 8;
    localparam int unsigned IMM_LSB      = 0;

    localparam logic [OPCODE_W-1:0] OPCODE_MAX = 4'd9;
    localparam logic [DMODE_W-1:0]  DMODE_MAX  = 3'd5;

    // opcode 0, dmode 0, imm_flag 1, imm 0
    localparam logic [INST_W-1:0] NOP_INST = 16'h0100;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [DMODE_W-1:0]  dmode;
        logic                imm_flag;
        logic [IMM_W-1:0]    imm;
    } inst_t;

    function automatic logic is_legal(input logic [OPCODE_W-1:0] opcode,
                                      input logic [DMODE_W-1:0]  dmode);
        return (opcode <= OPCODE_MAX) && (dmode <= DMODE_MAX);
    endfunction

endpackage

// File: rtl/simd_inst_fifo.sv
// DEPTH x WIDTH synchronous FIFO with flush; full/empty resolved by an extra pointer MSB.
module simd_inst_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level = wptr_q - rptr_q;
    assign rdata = mem_q[rptr_q[AW-1:0]];

    // Flush overrides both ports; a full FIFO never accepts, even alongside a pop.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/simd_inst_encoder.sv
// Packs SIMD ALU request fields into 16-bit instruction words, replacing illegal requests
// with the canonical NOP, and queues them for the instruction decoder.
module simd_inst_encoder
    import simd_isa_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ERR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_opcode,
    input  logic [2:0]             in_dmode,
    input  logic                   in_imm_flag,
    input  logic [7:0]             in_imm,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_inst,
    output logic                   err,
    output logic [ERR_W-1:0]       err_cnt,
    output logic [$clog2(DEPTH):0] level
);

    logic              illegal;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    inst_t             req_inst;
    logic [INST_W-1:0] enc_word;
    logic [INST_W-1:0] head_word;
    logic              err_q;
    logic [ERR_W-1:0]  err_cnt_q;

    assign illegal = !is_legal(in_opcode, in_dmode);

    always_comb begin
        req_inst.opcode   = in_opcode;
        req_inst.dmode    = in_dmode;
        req_inst.imm_flag = in_imm_flag;
        req_inst.imm      = in_imm;
    end

    assign enc_word = illegal ? NOP_INST : req_inst;

    // A request presented during flush is dropped, so it neither enqueues nor counts as an error.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready;

    simd_inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INST_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (enc_word),
        .rdata (head_word),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_inst  = out_valid ? head_word : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q <= push && illegal;
            if (push && illegal && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + ERR_W'(1);
            end
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule
